// File: rtl/spi_frame_regs_if.sv
// SPI pin bundle between a single SPI master and the register-frame slave.
// Signal names follow the board pin names.
interface spi_frame_regs_if;
   logic SCK;
   logic SSEL;
   logic MOSI;
   logic MISO;

   modport master (output SCK, output SSEL, output MOSI, input MISO);
   modport slave  (input SCK, input SSEL, input MOSI, output MISO);
endinterface

// File: rtl/spi_frame_regs.sv
// SPI-slave register-frame engine: NW little-endian words per SSEL assertion,
// read data snapshotted at frame start, write data committed only on a clean frame.
module spi_frame_regs #(
   parameter int NW  = 5,
   parameter int BW  = 4,
   parameter int CHK = 1
) (
   input  logic                clk,
   input  logic                reset,
   spi_frame_regs_if.slave     spi,
   input  logic [NW*BW*8-1:0]  rd_data,
   output logic [NW*BW*8-1:0]  wr_data,
   output logic                wr_strobe,
   output logic                frame_err,
   output logic [7:0]          err_cnt
);
   localparam int P  = NW * BW;
   localparam int L  = P + CHK;
   localparam int DW = P * 8;
   localparam logic [6:0] P_C   = 7'(P);
   localparam logic [6:0] L_C   = 7'(L);
   localparam logic [6:0] SAT_C = 7'(L + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_END} state_t;

   state_t        state_reg, state_next;
   logic          frame_start, shifting, in_end;

   logic [2:0]    sck_sync_reg, ssel_sync_reg;
   logic          sck_rise, sck_fall, ssel_rise, ssel_fall;

   logic [DW-1:0] snap_reg, shadow_reg, wr_data_reg;
   logic [6:0]    byte_cnt_reg, byte_cnt_next;
   logic [2:0]    bit_cnt_reg;
   logic          byte_done_reg;
   logic [7:0]    rx_byte_reg, rx_byte_next;
   logic [7:0]    rx_sum_reg, rx_chk_reg;
   logic [7:0]    tx_shift_reg, tx_sum, tx_byte_next;
   logic [7:0]    tx_table [128];
   logic          wr_strobe_reg, frame_err_reg;
   logic [7:0]    err_cnt_reg;
   logic          bit_in, byte_in, frame_ok;

   // Pin synchronisers are deliberately not reset: a reset with SSEL held low
   // must not manufacture a falling edge and restart a frame mid-stream.
   always_ff @(posedge clk) begin
      sck_sync_reg  <= {sck_sync_reg[1:0], spi.SCK};
      ssel_sync_reg <= {ssel_sync_reg[1:0], spi.SSEL};
   end

   assign sck_rise  =  sck_sync_reg[1]  & ~sck_sync_reg[2];
   assign sck_fall  = ~sck_sync_reg[1]  &  sck_sync_reg[2];
   assign ssel_rise =  ssel_sync_reg[1] & ~ssel_sync_reg[2];
   assign ssel_fall = ~ssel_sync_reg[1] &  ssel_sync_reg[2];

   always_ff @(posedge clk) begin
      if (reset) state_reg <= ST_IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next  = state_reg;
      frame_start = 1'b0;
      shifting    = 1'b0;
      in_end      = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (ssel_fall) begin
               frame_start = 1'b1;
               state_next  = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            shifting = 1'b1;
            if (ssel_rise) state_next = ST_END;
         end
         ST_END: begin
            in_end     = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      tx_sum = 8'h00;
      for (int i = 0; i < P; i++) tx_sum = tx_sum + snap_reg[i*8 +: 8];
   end

   // Transmit byte per frame position: payload, then checksum, then zero fill.
   generate
      for (genvar gi = 0; gi < 128; gi++) begin : g_tx_table
         if (gi < P) begin : g_payload
            assign tx_table[gi] = snap_reg[gi*8 +: 8];
         end else if (gi == P && CHK != 0) begin : g_chk
            assign tx_table[gi] = tx_sum;
         end else begin : g_zero
            assign tx_table[gi] = 8'h00;
         end
      end
   endgenerate

   assign rx_byte_next  = {rx_byte_reg[6:0], spi.MOSI};
   assign bit_in        = shifting & sck_rise;
   assign byte_in       = bit_in & (bit_cnt_reg == 3'd7);
   assign byte_cnt_next = (byte_cnt_reg == SAT_C) ? byte_cnt_reg : byte_cnt_reg + 7'd1;
   assign tx_byte_next  = tx_table[byte_cnt_next];
   assign frame_ok      = (byte_cnt_reg == L_C) && (bit_cnt_reg == 3'd0) &&
                          ((CHK == 0) || (rx_chk_reg == rx_sum_reg));

   always_ff @(posedge clk) begin
      if (reset) begin
         snap_reg      <= '0;
         shadow_reg    <= '0;
         wr_data_reg   <= '0;
         byte_cnt_reg  <= '0;
         bit_cnt_reg   <= '0;
         byte_done_reg <= 1'b0;
         rx_byte_reg   <= '0;
         rx_sum_reg    <= '0;
         rx_chk_reg    <= '0;
         tx_shift_reg  <= '0;
         wr_strobe_reg <= 1'b0;
         frame_err_reg <= 1'b0;
         err_cnt_reg   <= '0;
      end else begin
         wr_strobe_reg <= 1'b0;
         frame_err_reg <= 1'b0;

         if (frame_start) begin
            snap_reg      <= rd_data;
            byte_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            byte_done_reg <= 1'b0;
            rx_sum_reg    <= '0;
            rx_chk_reg    <= '0;
            tx_shift_reg  <= rd_data[7:0];
         end

         if (bit_in) begin
            rx_byte_reg <= rx_byte_next;
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
         end

         // Completed byte: payload goes to its shadow lane, checksum is kept aside.
         if (byte_in) begin
            byte_done_reg <= 1'b1;
            if (byte_cnt_reg < P_C) rx_sum_reg <= rx_sum_reg + rx_byte_next;
            if (CHK != 0 && byte_cnt_reg == P_C) rx_chk_reg <= rx_byte_next;
            for (int i = 0; i < P; i++) begin
               if (byte_cnt_reg == 7'(i)) shadow_reg[i*8 +: 8] <= rx_byte_next;
            end
         end

         if (shifting && sck_fall) begin
            if (byte_done_reg) begin
               byte_done_reg <= 1'b0;
               byte_cnt_reg  <= byte_cnt_next;
               tx_shift_reg  <= tx_byte_next;
            end else begin
               tx_shift_reg  <= {tx_shift_reg[6:0], 1'b0};
            end
         end

         if (in_end) begin
            if (frame_ok) begin
               wr_data_reg   <= shadow_reg;
               wr_strobe_reg <= 1'b1;
            end else begin
               frame_err_reg <= 1'b1;
               if (err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
            end
         end
      end
   end

   assign spi.MISO  = tx_shift_reg[7];
   assign wr_data   = wr_data_reg;
   assign wr_strobe = wr_strobe_reg;
   assign frame_err = frame_err_reg;
   assign err_cnt   = err_cnt_reg;
endmodule

// File: tb/tb_spi_frame_regs.sv
// Bench for spi_frame_regs: a default instance (5x32-bit words + checksum) and a
// minimal one-byte instance, both driven by a bit-level SPI master and a frame model.
module tb_spi_frame_regs;
   localparam int HALF = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic sck, mosi, ssel_a, ssel_b;

   spi_frame_regs_if bus_a ();
   spi_frame_regs_if bus_b ();
   assign bus_a.SCK  = sck;
   assign bus_a.MOSI = mosi;
   assign bus_a.SSEL = ssel_a;
   assign bus_b.SCK  = sck;
   assign bus_b.MOSI = mosi;
   assign bus_b.SSEL = ssel_b;

   logic [159:0] rd_a, wr_a;
   logic         stb_a, ferr_a;
   logic [7:0]   ecnt_a;
   logic [7:0]   rd_b, wr_b;
   logic         stb_b, ferr_b;
   logic [7:0]   ecnt_b;

   spi_frame_regs #(.NW(5), .BW(4), .CHK(1)) dut_a (
      .clk(clk), .reset(reset), .spi(bus_a),
      .rd_data(rd_a), .wr_data(wr_a), .wr_strobe(stb_a),
      .frame_err(ferr_a), .err_cnt(ecnt_a)
   );

   spi_frame_regs #(.NW(1), .BW(1), .CHK(0)) dut_b (
      .clk(clk), .reset(reset), .spi(bus_b),
      .rd_data(rd_b), .wr_data(wr_b), .wr_strobe(stb_b),
      .frame_err(ferr_b), .err_cnt(ecnt_b)
   );

   int checks = 0;
   int failures = 0;
   int stb_cnt [2] = '{0, 0};
   int ferr_cnt [2] = '{0, 0};
   int both_cnt = 0;

   // High-cycle counts: a pulse of exactly one cycle per frame shows up as +1.
   always @(negedge clk) begin
      if (stb_a)  stb_cnt[0]  <= stb_cnt[0] + 1;
      if (ferr_a) ferr_cnt[0] <= ferr_cnt[0] + 1;
      if (stb_b)  stb_cnt[1]  <= stb_cnt[1] + 1;
      if (ferr_b) ferr_cnt[1] <= ferr_cnt[1] + 1;
      if ((stb_a && ferr_a) || (stb_b && ferr_b)) both_cnt <= both_cnt + 1;
   end

   logic [7:0]   tx_q [$];
   logic [7:0]   rx_q [$];
   logic         first_bit;
   int           change_at = -1;
   int           reset_at = -1;
   logic [159:0] exp_wr [2];
   int           exp_ecnt [2];

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic xfer_bits(input logic [7:0] d, input int n, input int tgt, output logic [7:0] r);
      r = 8'h00;
      for (int i = 0; i < n; i++) begin
         mosi = d[7-i];
         wait_clk(HALF);
         r = {r[6:0], (tgt == 0) ? bus_a.MISO : bus_b.MISO};
         sck = 1'b1;
         wait_clk(HALF);
         sck = 1'b0;
      end
   endtask

   task automatic run_frame(input int tgt, input int nfull, input int extra);
      logic [7:0] r;
      rx_q.delete();
      if (tgt == 0) ssel_a = 1'b0; else ssel_b = 1'b0;
      wait_clk(3);
      first_bit = (tgt == 0) ? bus_a.MISO : bus_b.MISO;
      wait_clk(HALF);
      for (int b = 0; b < nfull; b++) begin
         if (b == change_at) rd_a[63:32] = 32'h5555_5555;
         if (b == reset_at) begin
            reset = 1'b1;
            wait_clk(3);
            reset = 1'b0;
         end
         xfer_bits(tx_q[b], 8, tgt, r);
         rx_q.push_back(r);
      end
      if (extra > 0) xfer_bits(tx_q[nfull], extra, tgt, r);
      wait_clk(HALF);
      ssel_a = 1'b1;
      ssel_b = 1'b1;
      wait_clk(10);
   endtask

   // Byte the slave should return at frame position b, from the frame-start snapshot.
   function automatic logic [7:0] exp_tx(input logic [159:0] snap, input int b, input int p,
                                         input bit has_chk, input int rst_at);
      logic [7:0] s = 8'h00;
      if (rst_at >= 0 && b >= rst_at) return 8'h00;
      if (b < p) return snap[b*8 +: 8];
      if (has_chk && b == p) begin
         for (int i = 0; i < p; i++) s = s + snap[i*8 +: 8];
         return s;
      end
      return 8'h00;
   endfunction

   task automatic fill_random();
      tx_q.delete();
      repeat (24) tx_q.push_back(8'($urandom));
   endtask

   task automatic set_chk(input logic [7:0] flip);
      logic [7:0] s = 8'h00;
      for (int i = 0; i < 20; i++) s = s + tx_q[i];
      tx_q[20] = s ^ flip;
   endtask

   task automatic frame(input int tgt, input string tag, input int nfull, input int extra);
      int p, l, s0, f0;
      bit has_chk, valid;
      logic [159:0] snap, obs_wr;
      logic [7:0] sum;
      p = (tgt == 0) ? 20 : 1;
      l = (tgt == 0) ? 21 : 1;
      has_chk = (tgt == 0);
      snap = (tgt == 0) ? rd_a : {152'd0, rd_b};
      s0 = stb_cnt[tgt];
      f0 = ferr_cnt[tgt];
      run_frame(tgt, nfull, extra);
      check({tag, "_miso_first_bit"}, 160'(first_bit), 160'(snap[7]));
      for (int b = 0; b < rx_q.size(); b++)
         check($sformatf("%s_miso[%0d]", tag, b), 160'(rx_q[b]),
               160'(exp_tx(snap, b, p, has_chk, reset_at)));
      sum = 8'h00;
      for (int i = 0; i < p; i++) sum = sum + tx_q[i];
      valid = (reset_at < 0) && (nfull == l) && (extra == 0) && (!has_chk || tx_q[p] == sum);
      if (reset_at >= 0) begin
         exp_wr[0] = '0;
         exp_wr[1] = '0;
         exp_ecnt[0] = 0;
         exp_ecnt[1] = 0;
      end else if (valid) begin
         exp_wr[tgt] = '0;
         for (int i = 0; i < p; i++) exp_wr[tgt][i*8 +: 8] = tx_q[i];
      end else if (exp_ecnt[tgt] < 255) begin
         exp_ecnt[tgt] = exp_ecnt[tgt] + 1;
      end
      obs_wr = (tgt == 0) ? wr_a : {152'd0, wr_b};
      check({tag, "_wr_data"}, obs_wr, exp_wr[tgt]);
      check({tag, "_err_cnt"}, 160'((tgt == 0) ? ecnt_a : ecnt_b), 160'(exp_ecnt[tgt]));
      check({tag, "_strobes"}, 160'(stb_cnt[tgt] - s0), 160'(valid ? 1 : 0));
      check({tag, "_errs"}, 160'(ferr_cnt[tgt] - f0), 160'((!valid && reset_at < 0) ? 1 : 0));
      $display("frame %s: bytes=%0d extra_bits=%0d valid=%0d", tag, nfull, extra, valid);
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog expired observed=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int kind, nf, ex, f0, s0;
      reset = 1'b1; sck = 1'b0; mosi = 1'b0; ssel_a = 1'b1; ssel_b = 1'b1;
      rd_a = '0; rd_b = '0;
      exp_wr[0] = '0; exp_wr[1] = '0; exp_ecnt[0] = 0; exp_ecnt[1] = 0;
      wait_clk(6);
      reset = 1'b0;
      wait_clk(2);
      check("rst_wr_a", wr_a, '0);
      check("rst_ecnt_a", 160'(ecnt_a), '0);
      check("rst_miso_a", 160'(bus_a.MISO), '0);
      check("rst_pulses_a", 160'({stb_a, ferr_a}), '0);
      check("rst_wr_b", 160'(wr_b), '0);

      // Nominal frame with fixed word0 on both directions.
      for (int w = 0; w < 5; w++) rd_a[w*32 +: 32] = $urandom;
      rd_a[31:0] = 32'h0001_2345;
      fill_random();
      tx_q[0] = 8'h44; tx_q[1] = 8'h33; tx_q[2] = 8'h22; tx_q[3] = 8'h11;
      set_chk(8'h00);
      frame(0, "nominal", 21, 0);
      check("nominal_word0", 160'(wr_a[31:0]), 160'(32'h1122_3344));

      set_chk(8'h01);
      frame(0, "bad_chk", 21, 0);
      set_chk(8'h00);
      frame(0, "short20", 20, 0);
      frame(0, "long22", 22, 0);
      frame(0, "cut3", 20, 3);

      // rd_data change mid-frame must not reach MISO.
      rd_a[63:32] = 32'hAAAA_AAAA;
      fill_random();
      set_chk(8'h00);
      change_at = 2;
      frame(0, "snapshot", 21, 0);
      change_at = -1;

      fill_random();
      set_chk(8'h00);
      reset_at = 10;
      frame(0, "reset_mid", 21, 0);
      reset_at = -1;
      fill_random();
      set_chk(8'h00);
      frame(0, "post_reset", 21, 0);

      for (int k = 0; k < 6; k++) begin
         kind = int'($urandom_range(0, 4));
         for (int w = 0; w < 5; w++) rd_a[w*32 +: 32] = $urandom;
         fill_random();
         set_chk((kind == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
         nf = (kind == 2 || kind == 4) ? 20 : (kind == 3) ? 22 : 21;
         ex = (kind == 4) ? int'($urandom_range(1, 7)) : 0;
         frame(0, $sformatf("rnd%0d_k%0d", k, kind), nf, ex);
      end

      // Minimal instance: one byte, no checksum.
      rd_b = 8'($urandom);
      fill_random();
      frame(1, "small_two", 2, 0);
      tx_q[0] = 8'h5A;
      frame(1, "small_one", 1, 0);
      check("small_wr_5a", 160'(wr_b), 160'(8'h5A));

      f0 = ferr_cnt[1];
      s0 = stb_cnt[1];
      for (int k = 0; k < 300; k++) begin
         ssel_b = 1'b0;
         wait_clk(HALF);
         ssel_b = 1'b1;
         wait_clk(8);
      end
      $display("small: 300 empty frames sent");
      check("small_ecnt_sat", 160'(ecnt_b), 160'(8'hFF));
      check("small_errs_300", 160'(ferr_cnt[1] - f0), 160'(300));
      check("small_no_strobe", 160'(stb_cnt[1] - s0), '0);
      check("small_wr_kept", 160'(wr_b), 160'(8'h5A));
      check("pulse_exclusive", 160'(both_cnt), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
